// File: rtl/mem_bus_arbiter.sv
// Arbiter/sequencer sharing one memory controller between fetch (F) and data (D) requesters.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate owners on contention instead of fixed D-over-F priority.
module mem_bus_arbiter #(
  parameter int WORD = 16,
  localparam int AW = WORD - (WORD / 8) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            f_req_i,
  input  logic [1:0]      f_sel_i,
  input  logic [AW-1:0]   f_addr_i,
  input  logic            d_req_i,
  input  logic            d_rw_i,
  input  logic            d_psw_i,
  input  logic [1:0]      d_sel_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [WORD-1:0] d_wdata_i,
  output logic            f_done_o,
  output logic            d_done_o,
  output logic [WORD-1:0] rdata_o,
  output logic [1:0]      gnt_o,
  output logic            mc_en_o,
  output logic            mc_rw_o,
  output logic            mc_psw_o,
  output logic [1:0]      mc_sel_o,
  output logic [AW-1:0]   mc_addr_o,
  output logic [WORD-1:0] mc_wdata_o,
  input  logic            mc_busy_i,
  input  logic [WORD-1:0] mc_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            mc_en_q, mc_en_d;
  logic            mc_rw_q, mc_rw_d;
  logic            mc_psw_q, mc_psw_d;
  logic [1:0]      mc_sel_q, mc_sel_d;
  logic [AW-1:0]   mc_addr_q, mc_addr_d;
  logic [WORD-1:0] mc_wdata_q, mc_wdata_d;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic            seen_busy_q, seen_busy_d;
  logic            f_done_q, f_done_d;
  logic            d_done_q, d_done_d;
  logic            d_wins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_is_d_q, last_is_d_d;

  // On contention the requester that did not own the last transfer wins.
  always_comb begin
    if (f_req_i && d_req_i) d_wins = ~last_is_d_q;
    else                    d_wins = d_req_i;
  end

  always_comb begin
    last_is_d_d = last_is_d_q;
    if (state_q == S_IDLE && (f_req_i || d_req_i)) last_is_d_d = d_wins;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_is_d_q <= 1'b0;
    else       last_is_d_q <= last_is_d_d;
  end
`else
  assign d_wins = d_req_i;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    mc_en_d     = 1'b0;
    mc_rw_d     = mc_rw_q;
    mc_psw_d    = mc_psw_q;
    mc_sel_d    = mc_sel_q;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;
    rdata_d     = rdata_q;
    seen_busy_d = seen_busy_q;
    f_done_d    = 1'b0;
    d_done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d = 2'b00;
        if (f_req_i || d_req_i) begin
          state_d = S_ISSUE;
          mc_en_d = 1'b1;
          if (d_wins) begin
            gnt_d      = 2'b10;
            mc_rw_d    = d_rw_i;
            mc_psw_d   = d_psw_i;
            mc_sel_d   = d_sel_i;
            mc_addr_d  = d_addr_i;
            mc_wdata_d = d_wdata_i;
          end else begin
            gnt_d     = 2'b01;
            mc_rw_d   = 1'b0;
            mc_psw_d  = 1'b0;
            mc_sel_d  = f_sel_i;
            mc_addr_d = f_addr_i;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mc_busy_i) begin
          rdata_d     = mc_rdata_i;
          seen_busy_d = 1'b1;
        end
        // Falling busy ends both ack-terminated and immediate PSW transfers.
        if (seen_busy_q && !mc_busy_i) begin
          state_d  = S_DONE;
          f_done_d = gnt_q[0];
          d_done_d = gnt_q[1];
        end
      end
      S_DONE: begin
        seen_busy_d = 1'b0;
        gnt_d       = 2'b00;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      mc_en_q     <= 1'b0;
      mc_rw_q     <= 1'b0;
      mc_psw_q    <= 1'b0;
      mc_sel_q    <= '0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
      rdata_q     <= '0;
      seen_busy_q <= 1'b0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mc_en_q     <= mc_en_d;
      mc_rw_q     <= mc_rw_d;
      mc_psw_q    <= mc_psw_d;
      mc_sel_q    <= mc_sel_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
      rdata_q     <= rdata_d;
      seen_busy_q <= seen_busy_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
    end
  end

  assign f_done_o   = f_done_q;
  assign d_done_o   = d_done_q;
  assign rdata_o    = rdata_q;
  assign gnt_o      = gnt_q;
  assign mc_en_o    = mc_en_q;
  assign mc_rw_o    = mc_rw_q;
  assign mc_psw_o   = mc_psw_q;
  assign mc_sel_o   = mc_sel_q;
  assign mc_addr_o  = mc_addr_q;
  assign mc_wdata_o = mc_wdata_q;

endmodule
